// File: rtl/riscv_defs.sv
// Opcode constants, branch-counter encodings and immediate helpers shared by the fetch path.
package riscv_defs;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // 2-bit saturating direction counter; MSB set means predict taken.
  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_ST  = 2'b11;

  typedef enum logic {
    ST_FETCH     = 1'b0,
    ST_JALR_WAIT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
  } iq_entry_t;

  // Callers pass only the instruction bits each format uses.
  function automatic logic [31:0] imm_j(input logic [31:12] w);
    return {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:25] hi, input logic [11:7] lo);
    return {{20{hi[31]}}, lo[7], hi[30:25], lo[11:8], 1'b0};
  endfunction

  function automatic logic [1:0] cnt_next(input logic [1:0] c, input logic taken);
    if (taken) return (c == CNT_ST) ? CNT_ST : c + 2'd1;
    else       return (c == CNT_SNT) ? CNT_SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/bht.sv
// Branch history table: 2-bit saturating counters, async read by fetch PC, write on branch resolve.
module bht
  import riscv_defs::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_taken_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  localparam int ENTRIES = 2 ** IDX_W;

  logic [1:0] cnt_q [ENTRIES];

  // Read is from the registered array, so a same-cycle update is not visible yet.
  assign rd_taken_o = cnt_q[rd_idx_i][1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_WNT;
    end else if (en_i && wr_en_i) begin
      cnt_q[wr_idx_i] <= cnt_next(cnt_q[wr_idx_i], wr_taken_i);
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: PC, memory request, JAL/branch/JALR pre-decode and instruction queue.
// Define BHT_PREDICT_EN to predict branch direction from the BHT; otherwise branches predict not-taken.
module ifetch
  import riscv_defs::*;
#(
  parameter int          IQ_DEPTH_LOG = 2,
  parameter int          BHT_IDX_W    = 6,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic [31:0] rollback_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_inst,
  input  logic        dec_stall,
  output logic        inst_rdy,
  output logic [31:0] inst,
  output logic [31:0] inst_PC,
  output logic        pred_jump,
  input  logic        JALR_need_pause,
  input  logic        JALR_pause_rej,
  input  logic [31:0] JALR_PC,
  input  logic        br_update,
  input  logic [31:0] br_pc,
  input  logic        br_taken
);

  localparam int IQ_DEPTH = 2 ** IQ_DEPTH_LOG;
  typedef logic [IQ_DEPTH_LOG-1:0] ptr_t;
  typedef logic [IQ_DEPTH_LOG:0]   cnt_t;

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  mem_addr_q;
  logic         mem_req_q;
  logic         drop_q;
  iq_entry_t    iq_q [IQ_DEPTH];
  ptr_t         head_q;
  ptr_t         tail_q;
  cnt_t         count_q;

  logic        empty, full, pop, push, can_issue, br_pred;
  logic [6:0]  opcode;
  logic [31:0] next_pc;
  logic        next_pred;

  assign empty = (count_q == '0);
  assign full  = (count_q == cnt_t'(IQ_DEPTH));

  assign inst_rdy  = !empty && !dec_stall && rdy;
  assign pop       = inst_rdy;
  assign inst      = iq_q[head_q].inst;
  assign inst_PC   = iq_q[head_q].pc;
  assign pred_jump = iq_q[head_q].pred;

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

  // A response landing in a rollback cycle, or while dropping, never enters the queue.
  assign push = mem_done && mem_req_q && !drop_q && !rollback;
  // With one request in flight and pushes only on its return, count < depth guarantees a slot.
  assign can_issue = (state_q == ST_FETCH) && !mem_req_q && !drop_q && !full;

`ifdef BHT_PREDICT_EN
  bht #(
    .IDX_W(BHT_IDX_W)
  ) u_bht (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (rdy),
    .rd_idx_i   (pc_q[BHT_IDX_W+1:2]),
    .rd_taken_o (br_pred),
    .wr_en_i    (br_update),
    .wr_idx_i   (br_pc[BHT_IDX_W+1:2]),
    .wr_taken_i (br_taken)
  );
  logic unused_br_pc;
  assign unused_br_pc = ^{br_pc[31:BHT_IDX_W+2], br_pc[1:0]};
`else
  assign br_pred = 1'b0;
  logic unused_br;
  assign unused_br = ^{br_update, br_pc, br_taken};
`endif

  always_comb begin
    opcode    = mem_inst[6:0];
    next_pc   = pc_q + 32'd4;
    next_pred = 1'b0;
    case (opcode)
      OP_JAL: begin
        next_pc   = pc_q + imm_j(mem_inst[31:12]);
        next_pred = 1'b1;
      end
      OP_BRANCH: begin
        if (br_pred) begin
          next_pc   = pc_q + imm_b(mem_inst[31:25], mem_inst[11:7]);
          next_pred = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      drop_q     <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < IQ_DEPTH; i++) iq_q[i] <= '0;
    end else if (rdy) begin
      if (rollback) begin
        state_q <= ST_FETCH;
        pc_q    <= rollback_pc;
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        // Requests are never cancelled; remember to swallow the one still in flight.
        drop_q  <= mem_req_q && !mem_done;
        if (mem_done) mem_req_q <= 1'b0;
      end else begin
        if (push) begin
          iq_q[tail_q] <= '{inst: mem_inst, pc: pc_q, pred: next_pred};
          tail_q       <= tail_q + ptr_t'(1);
        end
        if (pop) head_q <= head_q + ptr_t'(1);
        case ({push, pop})
          2'b10:   count_q <= count_q + cnt_t'(1);
          2'b01:   count_q <= count_q - cnt_t'(1);
          default: ;
        endcase

        if (mem_done && mem_req_q) begin
          mem_req_q <= 1'b0;
          drop_q    <= 1'b0;
        end else if (can_issue) begin
          mem_req_q  <= 1'b1;
          mem_addr_q <= pc_q;
        end

        case (state_q)
          ST_FETCH: begin
            if (push) begin
              if (opcode == OP_JALR) state_q <= ST_JALR_WAIT;
              else                   pc_q    <= next_pc;
            end
          end
          ST_JALR_WAIT: begin
            if (JALR_pause_rej && !JALR_need_pause) begin
              pc_q    <= JALR_PC;
              state_q <= ST_FETCH;
            end
          end
          default: state_q <= ST_FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: word memory responder, decoder-side pop monitor, hand-computed expectations.
module tb_ifetch;

  localparam logic [31:0] W_ADDI = 32'h00100093;
  localparam logic [31:0] W_JAL8 = 32'h0080006F;
  localparam logic [31:0] W_BEQ8 = 32'h00000463;
  localparam logic [31:0] W_JALR = 32'h00008067;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        rollback = 1'b0;
  logic [31:0] rollback_pc = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done = 1'b0;
  logic [31:0] mem_inst = '0;
  logic        dec_stall = 1'b0;
  logic        inst_rdy;
  logic [31:0] inst;
  logic [31:0] inst_PC;
  logic        pred_jump;
  logic        JALR_need_pause = 1'b0;
  logic        JALR_pause_rej = 1'b0;
  logic [31:0] JALR_PC = '0;
  logic        br_update = 1'b0;
  logic [31:0] br_pc = '0;
  logic        br_taken = 1'b0;

  always #5 clk = ~clk;

  ifetch dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .rollback_pc(rollback_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_done(mem_done), .mem_inst(mem_inst),
    .dec_stall(dec_stall), .inst_rdy(inst_rdy), .inst(inst), .inst_PC(inst_PC),
    .pred_jump(pred_jump), .JALR_need_pause(JALR_need_pause), .JALR_pause_rej(JALR_pause_rej),
    .JALR_PC(JALR_PC), .br_update(br_update), .br_pc(br_pc), .br_taken(br_taken)
  );

  logic [31:0] imem [256];
  logic        mem_en = 1'b1;
  int          lat = 0;
  logic [31:0] req_log [$];
  logic [31:0] pop_pc [$];
  logic [31:0] pop_inst [$];
  logic        pop_pred [$];
  int          n_chk = 0;
  int          n_fail = 0;

  // Memory: answers a held request on the second observation, one-cycle mem_done pulse.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      mem_done = 1'b0;
      if (mem_req && mem_en) begin
        if (lat >= 1) begin
          mem_done = 1'b1;
          mem_inst = imem[mem_addr[9:2]];
          req_log.push_back(mem_addr);
          lat = 0;
        end else begin
          lat++;
        end
      end else begin
        lat = 0;
      end
    end
  end

  // Decoder side: whatever is offered at the falling edge pops on the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (inst_rdy) begin
        pop_pc.push_back(inst_PC);
        pop_inst.push_back(inst);
        pop_pred.push_back(pred_jump);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] req_at(input int i);
    return (i < req_log.size()) ? req_log[i] : 32'hDEADBEEF;
  endfunction
  function automatic logic [31:0] pc_at(input int i);
    return (i < pop_pc.size()) ? pop_pc[i] : 32'hDEADBEEF;
  endfunction
  function automatic logic [31:0] inst_at(input int i);
    return (i < pop_inst.size()) ? pop_inst[i] : 32'hDEADBEEF;
  endfunction
  function automatic logic [31:0] pred_at(input int i);
    return (i < pop_pred.size()) ? 32'(pop_pred[i]) : 32'hDEADBEEF;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset, then a rollback cycle to park the PC without any request in flight.
  task automatic restart(input logic [31:0] pc);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    rollback = 1'b1;
    rollback_pc = pc;
    tick(1);
    rollback = 1'b0;
  endtask

  int rb, pb;
  logic [31:0] exp_br_pc;
  logic [31:0] exp_br_pred;

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = W_ADDI;
    imem[4]  = W_JAL8;
    imem[8]  = W_BEQ8;
    imem[12] = W_JALR;

    // Reset state
    tick(2);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_inst_rdy", 32'(inst_rdy), 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_PC", inst_PC, 32'h0);
    chk("rst_pred", 32'(pred_jump), 32'd0);

    // Straight line from 0
    restart(32'h0);
    rb = req_log.size(); pb = pop_pc.size();
    tick(15);
    chk("sl_req0", req_at(rb), 32'h0);
    chk("sl_req1", req_at(rb + 1), 32'h4);
    chk("sl_req2", req_at(rb + 2), 32'h8);
    chk("sl_pc0", pc_at(pb), 32'h0);
    chk("sl_pc1", pc_at(pb + 1), 32'h4);
    chk("sl_pc2", pc_at(pb + 2), 32'h8);
    chk("sl_inst0", inst_at(pb), W_ADDI);
    chk("sl_pred1", pred_at(pb + 1), 32'd0);

    // JAL +8 at 0x10
    restart(32'h10);
    rb = req_log.size(); pb = pop_pc.size();
    tick(12);
    chk("jal_req0", req_at(rb), 32'h10);
    chk("jal_req1", req_at(rb + 1), 32'h18);
    chk("jal_pc0", pc_at(pb), 32'h10);
    chk("jal_pred0", pred_at(pb), 32'd1);
    chk("jal_pc1", pc_at(pb + 1), 32'h18);
    chk("jal_pred1", pred_at(pb + 1), 32'd0);

    // BEQ +8 at 0x20 after two taken updates
`ifdef BHT_PREDICT_EN
    exp_br_pc = 32'h28; exp_br_pred = 32'd1;
`else
    exp_br_pc = 32'h24; exp_br_pred = 32'd0;
`endif
    mem_en = 1'b0;
    restart(32'h20);
    rb = req_log.size(); pb = pop_pc.size();
    br_update = 1'b1; br_pc = 32'h20; br_taken = 1'b1;
    tick(2);
    br_update = 1'b0; br_taken = 1'b0;
    mem_en = 1'b1;
    tick(10);
    chk("br_req0", req_at(rb), 32'h20);
    chk("br_req1", req_at(rb + 1), exp_br_pc);
    chk("br_pc0", pc_at(pb), 32'h20);
    chk("br_pred0", pred_at(pb), exp_br_pred);

    // JALR at 0x30: wait, ignore rej while still paused, then resolve to 0x100
    JALR_need_pause = 1'b1;
    restart(32'h30);
    rb = req_log.size(); pb = pop_pc.size();
    tick(12);
    chk("jalr_nreq", 32'(req_log.size() - rb), 32'd1);
    chk("jalr_wait_req", 32'(mem_req), 32'd0);
    chk("jalr_pc0", pc_at(pb), 32'h30);
    chk("jalr_pred0", pred_at(pb), 32'd0);
    JALR_pause_rej = 1'b1; JALR_PC = 32'h200;
    tick(1);
    JALR_pause_rej = 1'b0;
    tick(3);
    chk("jalr_still_wait", 32'(mem_req), 32'd0);
    JALR_need_pause = 1'b0; JALR_pause_rej = 1'b1; JALR_PC = 32'h100;
    tick(1);
    JALR_pause_rej = 1'b0; JALR_PC = 32'h0;
    tick(6);
    chk("jalr_req1", req_at(rb + 1), 32'h100);

    // Rollback with request to 0x40 in flight
    mem_en = 1'b0;
    restart(32'h40);
    rb = req_log.size(); pb = pop_pc.size();
    tick(2);
    chk("rb_req_up", 32'(mem_req), 32'd1);
    chk("rb_addr", mem_addr, 32'h40);
    rollback = 1'b1; rollback_pc = 32'h80;
    tick(1);
    rollback = 1'b0;
    chk("rb_req_held", 32'(mem_req), 32'd1);
    chk("rb_addr_held", mem_addr, 32'h40);
    chk("rb_empty", 32'(inst_rdy), 32'd0);
    mem_en = 1'b1;
    tick(10);
    chk("rb_req0", req_at(rb), 32'h40);
    chk("rb_req1", req_at(rb + 1), 32'h80);
    chk("rb_pc0", pc_at(pb), 32'h80);

    // Full queue under dec_stall, rdy freeze, then drain
    dec_stall = 1'b1;
    restart(32'h0);
    rb = req_log.size(); pb = pop_pc.size();
    tick(25);
    chk("full_nreq", 32'(req_log.size() - rb), 32'd4);
    chk("full_req_low", 32'(mem_req), 32'd0);
    chk("full_no_issue", 32'(inst_rdy), 32'd0);
    chk("full_head_pc", inst_PC, 32'h0);
    rdy = 1'b0; dec_stall = 1'b0;
    tick(1);
    chk("frz_inst_rdy", 32'(inst_rdy), 32'd0);
    tick(2);
    chk("frz_no_pop", 32'(pop_pc.size() - pb), 32'd0);
    rdy = 1'b1;
    tick(4);
    chk("drain_pc0", pc_at(pb), 32'h0);
    chk("drain_pc1", pc_at(pb + 1), 32'h4);
    chk("drain_pc2", pc_at(pb + 2), 32'h8);
    chk("drain_pc3", pc_at(pb + 3), 32'hC);
    tick(10);
    chk("resume_req", req_at(rb + 4), 32'h10);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
